// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the CPU MEM stage and a DMA port,
// with bounded DMA burst locking, read-return routing and a saturating CPU-stall counter.
module dmem_arbiter #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WIDTH-1:0]  cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [WIDTH-1:0]  cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [WIDTH-1:0]  dma_wdata,
    input  logic              dma_lock,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [WIDTH-1:0]  dma_rdata,
    output logic              mem_w_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned BurstW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);

    typedef enum logic {OwnCpu = 1'b0, OwnDma = 1'b1} owner_e;

    owner_e              last_owner_q, last_owner_d;
    owner_e              rd_owner_q, rd_owner_d;
    logic                rd_pend_q, rd_pend_d;
    logic                lock_q, lock_d;
    logic [BurstW-1:0]   burst_q, burst_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= OwnDma;
            rd_owner_q   <= OwnCpu;
            rd_pend_q    <= 1'b0;
            lock_q       <= 1'b0;
            burst_q      <= '0;
            stall_cnt_q  <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            rd_owner_q   <= rd_owner_d;
            rd_pend_q    <= rd_pend_d;
            lock_q       <= lock_d;
            burst_q      <= burst_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Grants: a held lock beats round-robin; otherwise the previous owner yields on conflict.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!reset) begin
            if (cpu_req && dma_req) begin
                if (lock_q || last_owner_q == OwnCpu) begin
                    dma_gnt = 1'b1;
                end else begin
                    cpu_gnt = 1'b1;
                end
            end else begin
                cpu_gnt = cpu_req;
                dma_gnt = dma_req;
            end
        end
    end

    always_comb begin
        mem_w_en  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_w_en  = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_w_en  = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;

    always_comb begin
        last_owner_d = last_owner_q;
        rd_owner_d   = rd_owner_q;
        rd_pend_d    = 1'b0;
        lock_d       = lock_q;
        burst_d      = burst_q;
        stall_cnt_d  = stall_cnt_q;

        if (cpu_gnt) begin
            last_owner_d = OwnCpu;
            if (!cpu_we) begin
                rd_pend_d  = 1'b1;
                rd_owner_d = OwnCpu;
            end
        end else if (dma_gnt) begin
            last_owner_d = OwnDma;
            if (!dma_we) begin
                rd_pend_d  = 1'b1;
                rd_owner_d = OwnDma;
            end
        end

        // The final locked grant of a burst releases the lock so the CPU gets the next conflict.
        if (dma_gnt) begin
            if (dma_lock && burst_q < BurstLast) begin
                lock_d  = 1'b1;
                burst_d = burst_q + BurstW'(1);
            end else begin
                lock_d  = 1'b0;
                burst_d = '0;
            end
        end else if (!dma_req) begin
            lock_d  = 1'b0;
            burst_d = '0;
        end

        if (cpu_stall && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Reset masks the return so a read granted just before reset never reports.
    always_comb begin
        cpu_rvalid = rd_pend_q && !reset && rd_owner_q == OwnCpu;
        dma_rvalid = rd_pend_q && !reset && rd_owner_q == OwnDma;
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dma_rdata  = dma_rvalid ? mem_rdata : '0;
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic, checked by a
// queue-based scoreboard against a transaction-level model of the arbiter and memory.
module tb_dmem_arbiter;

    localparam int unsigned W = 32;
    localparam int unsigned A = 6;
    localparam int unsigned MB = 4;
    localparam int unsigned C = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
    logic [A-1:0]  cpu_addr = '0, dma_addr = '0;
    logic [W-1:0]  cpu_wdata = '0, dma_wdata = '0;
    logic          cpu_gnt, cpu_rvalid, cpu_stall, dma_gnt, dma_rvalid, mem_w_en;
    logic [W-1:0]  cpu_rdata, dma_rdata, mem_wdata;
    logic [W-1:0]  mem_rdata = '0;
    logic [A-1:0]  mem_addr;
    logic [C-1:0]  stall_cnt;

    dmem_arbiter #(.WIDTH(W), .ADDR_W(A), .MAX_BURST(MB), .CNT_W(C)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_w_en(mem_w_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read data memory
    logic [W-1:0] tb_mem [64] = '{default: 32'h0};
    always @(posedge clk) begin
        if (mem_w_en) tb_mem[mem_addr] <= mem_wdata;
        mem_rdata <= tb_mem[mem_addr];
    end

    typedef struct {
        logic         cg, dg, we, stall;
        logic [A-1:0] addr;
        logic [W-1:0] wd;
        logic [C-1:0] scnt;
    } cyc_exp_t;

    typedef struct {
        int           due;
        bit           dma;
        logic [W-1:0] data;
    } rd_exp_t;

    cyc_exp_t exp_q[$];
    rd_exp_t  rd_q[$];

    int n_tests = 0;
    int n_fail = 0;
    bit mon_en = 1'b0;

    // Reference model state
    bit           m_last_dma = 1'b1;
    bit           m_lock = 1'b0;
    int           m_burst = 0;
    int           m_scnt = 0;
    logic [W-1:0] ref_mem [64] = '{default: 32'h0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of requests and push what the arbiter must do with them.
    task automatic step(input bit rst, input bit creq, input bit cwe, input logic [A-1:0] caddr,
                        input logic [W-1:0] cwd, input bit dreq, input bit dwe,
                        input logic [A-1:0] daddr, input logic [W-1:0] dwd, input bit dlock,
                        output bit cg, output bit dg);
        cyc_exp_t e;
        rd_exp_t  r;
        @(posedge clk);
        #1;
        reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd; dma_lock = dlock;

        if (rst) begin
            cg = 0; dg = 0;
        end else if (creq && dreq) begin
            dg = m_lock || !m_last_dma;
            cg = !dg;
        end else begin
            cg = creq; dg = dreq;
        end
        e.cg = cg; e.dg = dg;
        e.we = (cg && cwe) || (dg && dwe);
        e.addr = cg ? caddr : (dg ? daddr : '0);
        e.wd = cg ? cwd : (dg ? dwd : '0);
        e.stall = creq && !cg;
        e.scnt = C'(m_scnt);
        exp_q.push_back(e);
        mon_en = 1'b1;

        if (rst) begin
            rd_q.delete();
            m_last_dma = 1; m_lock = 0; m_burst = 0; m_scnt = 0;
            return;
        end
        if (cg) begin
            m_last_dma = 0;
            if (cwe) ref_mem[caddr] = cwd;
            else begin r.due = cyc + 1; r.dma = 0; r.data = ref_mem[caddr]; rd_q.push_back(r); end
        end
        if (dg) begin
            m_last_dma = 1;
            if (dwe) ref_mem[daddr] = dwd;
            else begin r.due = cyc + 1; r.dma = 1; r.data = ref_mem[daddr]; rd_q.push_back(r); end
            if (dlock && m_burst < MB - 1) begin m_lock = 1; m_burst++; end
            else begin m_lock = 0; m_burst = 0; end
        end else if (!dreq) begin
            m_lock = 0; m_burst = 0;
        end
        if (e.stall && m_scnt < (1 << C) - 1) m_scnt++;
    endtask

    task automatic idle(input bit rst);
        bit cg, dg;
        step(rst, 0, 0, '0, '0, 0, 0, '0, '0, 0, cg, dg);
    endtask

    // Monitor: compare every cycle's outputs and any due read return.
    always @(negedge clk) begin
        cyc_exp_t e;
        rd_exp_t  r;
        bit       ev_c, ev_d;
        logic [W-1:0] ed_c, ed_d;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cpu_gnt", 32'(cpu_gnt), 32'(e.cg));
                check("dma_gnt", 32'(dma_gnt), 32'(e.dg));
                check("mem_w_en", 32'(mem_w_en), 32'(e.we));
                check("mem_addr", 32'(mem_addr), 32'(e.addr));
                check("mem_wdata", mem_wdata, e.wd);
                check("cpu_stall", 32'(cpu_stall), 32'(e.stall));
                check("stall_cnt", 32'(stall_cnt), 32'(e.scnt));
            end
            while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
                r = rd_q.pop_front();
                check("rd_missed", 32'(r.due), 32'(cyc));
            end
            ev_c = 0; ev_d = 0; ed_c = '0; ed_d = '0;
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                r = rd_q.pop_front();
                if (r.dma) begin ev_d = 1; ed_d = r.data; end
                else begin ev_c = 1; ed_c = r.data; end
            end
            check("cpu_rvalid", 32'(cpu_rvalid), 32'(ev_c));
            check("dma_rvalid", 32'(dma_rvalid), 32'(ev_d));
            check("cpu_rdata", cpu_rdata, ed_c);
            check("dma_rdata", dma_rdata, ed_d);
        end
    end

    initial begin
        bit cg, dg;
        bit c_act, d_act, cwe_h, dwe_h;
        logic [A-1:0] ca_h, da_h;
        logic [W-1:0] cw_h, dw_h;
        int nstall;
        logic [7:0] dseq, dseq_exp;

        idle(1); idle(1);
        idle(0);
        #1;
        check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        check("rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'h0);

        // CPU-only write then read
        step(0, 1, 1, 6'd5, 32'hDEADBEEF, 0, 0, '0, '0, 0, cg, dg);
        #1; check("t1_wr_gnt", 32'(cpu_gnt), 32'h1); check("t1_w_en", 32'(mem_w_en), 32'h1);
        step(0, 1, 0, 6'd5, '0, 0, 0, '0, '0, 0, cg, dg);
        #1; check("t1_rd_gnt", 32'(cpu_gnt), 32'h1); check("t1_rd_w_en", 32'(mem_w_en), 32'h0);
        idle(0);
        #1; check("t1_rvalid", 32'(cpu_rvalid), 32'h1); check("t1_rdata", cpu_rdata, 32'hDEADBEEF);

        // Conflict right after reset alternates starting with the CPU
        idle(1);
        dseq = '0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 6'(i), '0, 1, 0, 6'(i + 8), '0, 0, cg, dg);
            dseq[i] = dg;
        end
        check("t2_grant_seq", 32'(dseq[3:0]), 32'h0000000A);
        idle(0);
        #1; check("t2_stall_cnt", 32'(stall_cnt), 32'h2);

        // Locked DMA burst bounded at MB grants
        step(0, 1, 1, 6'd20, 32'h1, 0, 0, '0, '0, 0, cg, dg);
        dseq = '0; nstall = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 6'd10, 32'hC0DE0000, 1, 1, 6'(30 + i), 32'(i), 1, cg, dg);
            #1; dseq[i] = dg;
            if (i < 5 && cpu_stall) nstall++;
        end
        dseq_exp = 8'b1110_1111;
        check("t3_grant_seq", 32'(dseq), 32'(dseq_exp));
        check("t3_stall_cycles", 32'(nstall), 32'h4);
        idle(0);

        // Interleaved reads routed to their owners
        step(0, 1, 1, 6'd1, 32'h11111111, 0, 0, '0, '0, 0, cg, dg);
        step(0, 0, 0, '0, '0, 1, 1, 6'd2, 32'h22222222, 0, cg, dg);
        step(0, 1, 0, 6'd1, '0, 0, 0, '0, '0, 0, cg, dg);
        step(0, 0, 0, '0, '0, 1, 0, 6'd2, '0, 0, cg, dg);
        #1; check("t4_cpu_rdata", cpu_rdata, 32'h11111111); check("t4_dma_rdata0", dma_rdata, 32'h0);
        idle(0);
        #1; check("t4_dma_rdata", dma_rdata, 32'h22222222); check("t4_cpu_rdata0", cpu_rdata, 32'h0);
        check("t4_cpu_rvalid0", 32'(cpu_rvalid), 32'h0);

        // Reset right after a granted read discards it
        step(0, 1, 0, 6'd5, '0, 0, 0, '0, '0, 0, cg, dg);
        step(1, 1, 1, 6'd7, 32'h5, 1, 1, 6'd8, 32'h6, 0, cg, dg);
        #1; check("t5_rvalid", 32'(cpu_rvalid), 32'h0); check("t5_gnt", 32'({cpu_gnt, dma_gnt}), 32'h0);
        check("t5_w_en", 32'(mem_w_en), 32'h0); check("t5_stall", 32'(cpu_stall), 32'h1);
        idle(0);
        #1; check("t5_stall_cnt", 32'(stall_cnt), 32'h0); check("t5_rvalid_after", 32'(cpu_rvalid), 32'h0);

        // Saturation of the stall counter
        for (int i = 0; i < 40; i++) step(0, 1, 0, 6'(i), '0, 1, 0, 6'(i + 1), '0, 0, cg, dg);
        idle(0);
        #1; check("t6_saturated", 32'(stall_cnt), 32'hF);

        // Randomized traffic obeying the hold-until-grant protocol
        c_act = 0; d_act = 0;
        cwe_h = 0; dwe_h = 0; ca_h = '0; da_h = '0; cw_h = '0; dw_h = '0;
        for (int i = 0; i < 400; i++) begin
            if (!c_act && $urandom_range(0, 99) < 60) begin
                c_act = 1; cwe_h = 1'($urandom_range(0, 1));
                ca_h = 6'($urandom_range(0, 7)); cw_h = $urandom;
            end
            if (!d_act && $urandom_range(0, 99) < 60) begin
                d_act = 1; dwe_h = 1'($urandom_range(0, 1));
                da_h = 6'($urandom_range(0, 7)); dw_h = $urandom;
            end
            step($urandom_range(0, 99) == 0, c_act, cwe_h, ca_h, cw_h, d_act, dwe_h, da_h, dw_h,
                 $urandom_range(0, 99) < 70, cg, dg);
            if (cg) c_act = 0;
            if (dg) d_act = 0;
        end
        idle(0); idle(0); idle(0);
        @(posedge clk); #1;
        check("rd_q_drained", 32'(rd_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 64-word data memory between two requesters: the CPU MEM stage and a DMA/loader port.
- Performs round-robin arbitration with an optional bounded DMA burst lock.
- Tracks the one-cycle read return and routes read data back to the requester that issued the read.
- Drives a stall to the pipeline when the CPU is refused, and keeps a saturating CPU-stall performance counter.

Parameters:
- WIDTH, 32, data width of memory words and of both requester ports.
- ADDR_W, 6, word-address width (matches the 64-entry data memory).
- MAX_BURST, 4, maximum consecutive locked DMA grants before the CPU must be served.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU memory access request.
- cpu_we  in  1  CPU request is a write.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  WIDTH  CPU write data.
- cpu_gnt  out  1  CPU access accepted this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  WIDTH  CPU read data.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; holds the pipeline.
- dma_req  in  1  DMA request.
- dma_we  in  1  DMA request is a write.
- dma_addr  in  ADDR_W  DMA word address.
- dma_wdata  in  WIDTH  DMA write data.
- dma_lock  in  1  DMA asks to keep ownership for its next access.
- dma_gnt  out  1  DMA access accepted this cycle.
- dma_rvalid  out  1  DMA read data valid.
- dma_rdata  out  WIDTH  DMA read data.
- mem_w_en  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data, valid one cycle after the address.
- stall_cnt  out  CNT_W  saturating count of cycles with cpu_stall = 1.

Behaviour:

Handshake
- A requester holds req, we, addr and wdata stable until it samples gnt = 1.
- A transfer occurs in a cycle where req & gnt = 1. At most one transfer per cycle; at most one gnt is high.
- Grants are combinational from the current requests and registered state. Zero-latency accept.

Arbitration
- Only one requester active: it is granted.
- Both active: grant the requester that is not last_owner.
- Override: if lock_active = 1, DMA wins regardless of last_owner.
- last_owner (1 bit) updates on every transfer. Reset value = DMA, so the CPU wins the first conflict.
- lock_active is set when a DMA transfer occurs with dma_lock = 1 and burst_cnt < MAX_BURST-1.
- burst_cnt increments on each locked DMA transfer.
- lock_active and burst_cnt clear when:
  - a DMA transfer occurs with dma_lock = 0, or
  - burst_cnt reaches MAX_BURST-1 (the next conflict goes to the CPU), or
  - a cycle passes with no DMA request.

Memory side
- mem_addr, mem_wdata and mem_w_en are muxed combinationally from the granted requester.
- mem_w_en = gnt & we.
- With no grant, all three outputs are driven to 0.

Read return
- A granted read (we = 0) sets rd_pend = 1 and rd_owner = winner at the clock edge.
- In the next cycle the owner's rvalid = 1 and its rdata = mem_rdata. The other requester's rdata is driven to 0.
- A new read may be granted in that same cycle (back-to-back reads, one per cycle).
- A granted write does not set rd_pend.

Stall counter
- stall_cnt increments each cycle where cpu_stall = 1.
- It saturates at all-ones and never wraps.

Reset
- While reset = 1, both gnt are forced to 0 and mem_w_en = 0.
- cpu_stall = cpu_req during reset.
- Registers clear at the edge: rd_pend = 0, last_owner = DMA, lock_active = 0, burst_cnt = 0, stall_cnt = 0.
- After reset: both rvalid = 0 and both rdata = 0.
- Reset mid-operation: a pending read is discarded and no rvalid is issued in the cycle after reset.

Test Plan:
1. CPU-only write then read: cpu_we = 1, addr = 5, wdata = 0xDEADBEEF, then cpu read of addr 5 -> cpu_gnt = 1 in both cycles; mem_w_en = 1 in the first cycle; cpu_rvalid = 1 with cpu_rdata = 0xDEADBEEF one cycle after the read grant; cpu_stall = 0 throughout.
2. Simultaneous requests for 4 cycles right after reset -> grants alternate CPU, DMA, CPU, DMA; stall_cnt = 2 afterwards.
3. DMA lock burst: dma_lock = 1 and cpu_req held high for 8 cycles, MAX_BURST = 4 -> DMA granted 4 consecutive cycles, then the CPU is granted; cpu_stall = 1 for exactly those 4 cycles.
4. Interleaved reads: CPU reads addr 1, then DMA reads addr 2 in the next cycle -> cpu_rvalid on cycle 2 only, dma_rvalid on cycle 3 only, each with the correct word; the other side's rdata = 0 on those cycles.
5. Reset asserted the cycle after a granted CPU read -> no cpu_rvalid; all gnt = 0 and mem_w_en = 0 during reset; stall_cnt = 0 afterwards.
6. Force stall_cnt to all-ones with CNT_W = 4 (16+ stall cycles) -> it holds at 15 and never wraps to 0.
